// File: rtl/dram_read_arbiter.sv
// dram_read_arbiter
// Round-robin arbiter that gives two requesters (A, B) shared access to a
// single DRAM read block. It keeps at most one read outstanding, abandons
// a read after TIMEOUT cycles in WAIT, and returns either the data or a
// timeout error to the requester that was granted.
//
// Optional feature: define ROW_HIT_PRIO_EN to enable row-hit priority. When
// both requesters are valid and only one of them asks for the row of the
// last good read, that one is granted. A streak limit of 4 consecutive
// overrides keeps the other requester from starving.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   req_valid_a/b, req_row_a/b request handshake and row, per requester
//   req_ready_a/b              combinational grant (only in IDLE)
//   mem_valid, mem_row         one-cycle issue strobe and row to the DRAM block
//   mem_content, mem_done      read data and completion from the DRAM block
//   resp_valid_a/b             one-cycle response strobe, per requester
//   resp_data, resp_err        response data (0 on error) and timeout flag
//   busy                       high whenever the FSM is not in IDLE
//
// state | meaning
// IDLE  | arbitrate between pending requests, latch row and requester
// ISSUE | present mem_valid/mem_row to the DRAM block for one cycle
// WAIT  | wait for mem_done, or give up when the counter hits TIMEOUT-1
// RESP  | strobe resp_valid to the granted requester

module dram_read_arbiter #(
    parameter int TIMEOUT = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_a,
    input  logic        req_valid_b,
    input  logic [3:0]  req_row_a,
    input  logic [3:0]  req_row_b,
    output logic        req_ready_a,
    output logic        req_ready_b,
    output logic        mem_valid,
    output logic [3:0]  mem_row,
    input  logic [31:0] mem_content,
    input  logic        mem_done,
    output logic        resp_valid_a,
    output logic        resp_valid_b,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [4:0] CNT_LAST = 5'(TIMEOUT - 1);

    state_t     state;
    logic       ptr;        // 0 prefers A, 1 prefers B
    logic       gnt_b;      // requester of the outstanding read
    logic [4:0] wait_cnt;
    logic       grant_a;
    logic       grant_b;
    logic       override;

`ifdef ROW_HIT_PRIO_EN
    // last_row only feeds row-hit priority, so it lives with that feature.
    logic [3:0] last_row;
    logic       last_row_valid;
    logic [2:0] hit_streak;
    logic       hit_a;
    logic       hit_b;

    assign hit_a = last_row_valid && (req_row_a == last_row);
    assign hit_b = last_row_valid && (req_row_b == last_row);
`endif

    always_comb begin
        grant_a  = 1'b0;
        grant_b  = 1'b0;
        override = 1'b0;
        if (!rst && state == IDLE) begin
            if (req_valid_a && req_valid_b) begin
`ifdef ROW_HIT_PRIO_EN
                // A streak of 4 forces one plain round-robin grant.
                if ((hit_a != hit_b) && (hit_streak != 3'd4)) begin
                    override = 1'b1;
                    grant_a  = hit_a;
                    grant_b  = hit_b;
                end else begin
                    grant_a = !ptr;
                    grant_b = ptr;
                end
`else
                grant_a = !ptr;
                grant_b = ptr;
`endif
            end else begin
                grant_a = req_valid_a;
                grant_b = req_valid_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            gnt_b     <= 1'b0;
            wait_cnt  <= 5'd0;
            mem_row   <= 4'd0;
            resp_data <= 32'd0;
            resp_err  <= 1'b0;
`ifdef ROW_HIT_PRIO_EN
            last_row       <= 4'd0;
            last_row_valid <= 1'b0;
            hit_streak     <= 3'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_a || grant_b) begin
                        gnt_b   <= grant_b;
                        mem_row <= grant_b ? req_row_b : req_row_a;
                        // Pointer moves to the requester not just served.
                        if (!override)
                            ptr <= grant_a;
`ifdef ROW_HIT_PRIO_EN
                        hit_streak <= override ? hit_streak + 3'd1 : 3'd0;
`endif
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= 5'd0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (mem_done) begin
                        resp_data <= mem_content;
                        resp_err  <= 1'b0;
`ifdef ROW_HIT_PRIO_EN
                        last_row       <= mem_row;
                        last_row_valid <= 1'b1;
`endif
                        state <= RESP;
                    end else if (wait_cnt == CNT_LAST) begin
                        resp_data <= 32'd0;
                        resp_err  <= 1'b1;
`ifdef ROW_HIT_PRIO_EN
                        last_row_valid <= 1'b0;
`endif
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 5'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Strobes are state decodes, forced low while reset is asserted.
    assign req_ready_a  = grant_a;
    assign req_ready_b  = grant_b;
    assign mem_valid    = !rst && (state == ISSUE);
    assign resp_valid_a = !rst && (state == RESP) && !gnt_b;
    assign resp_valid_b = !rst && (state == RESP) && gnt_b;
    assign busy         = !rst && (state != IDLE);

endmodule

// File: tb/tb_dram_read_arbiter.sv
module tb_dram_read_arbiter;

    logic        clk;
    logic        rst;
    logic        req_valid_a, req_valid_b;
    logic [3:0]  req_row_a, req_row_b;
    logic        req_ready_a, req_ready_b;
    logic        mem_valid;
    logic [3:0]  mem_row;
    logic [31:0] mem_content;
    logic        mem_done;
    logic        resp_valid_a, resp_valid_b;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    dram_read_arbiter #(.TIMEOUT(20)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_a  (req_valid_a),
        .req_valid_b  (req_valid_b),
        .req_row_a    (req_row_a),
        .req_row_b    (req_row_b),
        .req_ready_a  (req_ready_a),
        .req_ready_b  (req_ready_b),
        .mem_valid    (mem_valid),
        .mem_row      (mem_row),
        .mem_content  (mem_content),
        .mem_done     (mem_done),
        .resp_valid_a (resp_valid_a),
        .resp_valid_b (resp_valid_b),
        .resp_data    (resp_data),
        .resp_err     (resp_err),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        va;
        logic        vb;
        logic [3:0]  ra;
        logic [3:0]  rb;
        int          delay;     // cycles from mem_valid to mem_done; -1 = never
        logic [31:0] content;
        logic        exp_b;
        logic [3:0]  exp_row;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in an IDLE cycle with requests already driven.
    task automatic serve(input logic exp_b, input logic [3:0] exp_row, input int delay,
                         input logic [31:0] content, input logic exp_err,
                         input logic [31:0] exp_data);
        int n;
        #1;
        check("req_ready_a", req_ready_a, !exp_b);
        check("req_ready_b", req_ready_b, exp_b);
        tick();
        check("mem_valid_issue", mem_valid, 1'b1);
        check("mem_row", mem_row, exp_row);
        check("busy_issue", busy, 1'b1);
        if (delay < 0) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (!(resp_valid_a || resp_valid_b) && n < 40);
            check("timeout_latency", n, 21);
        end else begin
            repeat (delay) tick();
            check("mem_valid_wait", mem_valid, 1'b0);
            mem_done    = 1'b1;
            mem_content = content;
            tick();
            mem_done    = 1'b0;
        end
        check("resp_valid_a", resp_valid_a, !exp_b);
        check("resp_valid_b", resp_valid_b, exp_b);
        check("resp_data", resp_data, exp_data);
        check("resp_err", resp_err, exp_err);
        tick();
        check("resp_valid_after", {resp_valid_a, resp_valid_b}, 2'b00);
        check("busy_idle", busy, 1'b0);
        check("resp_data_hold", resp_data, exp_data);
    endtask

    logic cseq [6];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 4'd2,  4'd0,  3,  32'hDEADBEEF, 1'b0, 4'd2,  1'b0, 32'hDEADBEEF};
        tbl[1] = '{1'b0, 1'b1, 4'd0,  4'd5,  1,  32'h11111111, 1'b1, 4'd5,  1'b0, 32'h11111111};
        tbl[2] = '{1'b1, 1'b1, 4'd9,  4'd15, 2,  32'hA5A5A5A5, 1'b0, 4'd9,  1'b0, 32'hA5A5A5A5};
        tbl[3] = '{1'b1, 1'b1, 4'd4,  4'd15, 1,  32'h5A5A5A5A, 1'b1, 4'd15, 1'b0, 32'h5A5A5A5A};
        tbl[4] = '{1'b1, 1'b1, 4'd9,  4'd8,  4,  32'hC0FFEE00, 1'b0, 4'd9,  1'b0, 32'hC0FFEE00};
        tbl[5] = '{1'b1, 1'b1, 4'd12, 4'd13, 5,  32'h12345678, 1'b1, 4'd13, 1'b0, 32'h12345678};
        tbl[6] = '{1'b0, 1'b1, 4'd0,  4'd3,  1,  32'h87654321, 1'b1, 4'd3,  1'b0, 32'h87654321};
        tbl[7] = '{1'b1, 1'b0, 4'd7,  4'd0,  -1, 32'hFFFFFFFF, 1'b0, 4'd7,  1'b1, 32'h00000000};
        tbl[8] = '{1'b1, 1'b0, 4'd1,  4'd0,  2,  32'h0BADF00D, 1'b0, 4'd1,  1'b0, 32'h0BADF00D};

`ifdef ROW_HIT_PRIO_EN
        cseq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
        cseq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif

        // Reset, with both requesters already pending.
        rst = 1'b1;
        req_valid_a = 1'b1; req_row_a = 4'd9;
        req_valid_b = 1'b1; req_row_b = 4'd15;
        mem_done = 1'b0; mem_content = 32'd0;
        repeat (3) tick();
        check("rst_ready", {req_ready_a, req_ready_b}, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_mem_valid", mem_valid, 1'b0);
        check("rst_resp_valid", {resp_valid_a, resp_valid_b}, 2'b00);
        check("rst_mem_row", mem_row, 4'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_resp_err", resp_err, 1'b0);
        rst = 1'b0;

        // Contention held from reset (row-hit build: first grant sets last_row=9).
        for (int i = 0; i < 6; i++)
            serve(cseq[i], cseq[i] ? 4'd15 : 4'd9, 1, 32'h100 + i, 1'b0, 32'h100 + i);

        // Reset while a read is outstanding, then a stray mem_done.
        req_valid_b = 1'b0;
        req_row_a   = 4'd6;
        #1;
        check("rw_ready_a", req_ready_a, 1'b1);
        tick();
        check("rw_mem_row", mem_row, 4'd6);
        req_valid_a = 1'b0;
        tick();
        tick();
        check("rw_busy_wait", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("rw_busy_in_rst", busy, 1'b0);
        check("rw_resp_in_rst", {resp_valid_a, resp_valid_b}, 2'b00);
        tick();
        check("rw_mem_row_rst", mem_row, 4'd0);
        check("rw_resp_data_rst", resp_data, 32'd0);
        rst = 1'b0;
        mem_done = 1'b1;
        mem_content = 32'hFFFFFFFF;
        tick();
        mem_done = 1'b0;
        check("rw_stray_resp", {resp_valid_a, resp_valid_b}, 2'b00);
        check("rw_stray_busy", busy, 1'b0);
        check("rw_stray_data", resp_data, 32'd0);
        tick();
        check("rw_idle_resp", {resp_valid_a, resp_valid_b}, 2'b00);
        check("rw_idle_busy", busy, 1'b0);

        // Directed table: single reads, contention, timeout.
        for (int i = 0; i < 9; i++) begin
            req_valid_a = tbl[i].va; req_row_a = tbl[i].ra;
            req_valid_b = tbl[i].vb; req_row_b = tbl[i].rb;
            serve(tbl[i].exp_b, tbl[i].exp_row, tbl[i].delay, tbl[i].content,
                  tbl[i].exp_err, tbl[i].exp_data);
            req_valid_a = 1'b0;
            req_valid_b = 1'b0;
        end

        // mem_done in IDLE must not touch state or data.
        mem_done = 1'b1;
        mem_content = 32'h12345678;
        tick();
        mem_done = 1'b0;
        check("idle_done_busy", busy, 1'b0);
        check("idle_done_resp", {resp_valid_a, resp_valid_b}, 2'b00);
        check("idle_done_data", resp_data, 32'h0BADF00D);
        check("idle_done_err", resp_err, 1'b0);
        tick();
        check("idle_done_busy2", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dram_read_arbiter.md
DRAM_READ_ARBITER -- requirements
Module: dram_read_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 20, sets the max cycles spent in WAIT before the request is abandoned; legal range 2..31.
REQ-002 clk  input  1  sole clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req_valid_a / req_valid_b  input  1 each  requester A/B has a read pending.
REQ-005 req_row_a / req_row_b  input  4 each  row requested by A/B; stable while the matching req_valid is high.
REQ-006 req_ready_a / req_ready_b  output  1 each  grant; a request is accepted when valid and ready are both high.
REQ-007 mem_valid  output  1  one-cycle issue strobe to the DRAM read block (its input_valid).
REQ-008 mem_row  output  4  row presented to the DRAM read block.
REQ-009 mem_content  input  32  data from the DRAM read block.
REQ-010 mem_done  input  1  completion from the DRAM read block (its output_valid).
REQ-011 resp_valid_a / resp_valid_b  output  1 each  one-cycle response strobe to A/B.
REQ-012 resp_data  output  32  response data; 0 on error.
REQ-013 resp_err  output  1  qualifies resp_valid_*; 1 means timeout.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have four states: IDLE, ISSUE, WAIT and RESP; at most one read SHALL be outstanding.
REQ-016 IDLE: if any req_valid is high, the SHALL assert exactly one req_ready combinationally, latch row and requester id, and go to ISSUE next cycle; otherwise it SHALL stay in IDLE.
REQ-017 Arbitration SHALL be round-robin:
- a 1-bit pointer, reset to A, names the preferred requester;
- when only one requester is valid, that requester is granted;
- after each grant the pointer moves to the other requester.
REQ-018 ISSUE: mem_valid=1 and mem_row=latched row for exactly one cycle, then go to WAIT; outside ISSUE, mem_valid=0 and mem_row holds its last value.
REQ-019 WAIT: a 5-bit counter SHALL start at 0 on entry and increment each cycle.
- When mem_done=1: capture mem_content, set the error flag to 0, go to RESP.
- Else when the counter equals TIMEOUT-1: set the error flag to 1 and data to 0, go to RESP.
- mem_done takes priority over the timeout in the same cycle.
REQ-020 RESP: the granted requester's resp_valid SHALL be 1 for one cycle, with resp_data and resp_err driven; then go to IDLE.
REQ-021 Read latency: acceptance at cycle N gives mem_valid at N+1; mem_done at cycle M gives resp_valid at M+1.
REQ-022 resp_data and resp_err SHALL hold their values between responses.
REQ-023 mem_done outside WAIT SHALL be ignored and SHALL NOT change state or data.
REQ-024 On a non-error completion, last_row SHALL be set to the latched row and last_row_valid to 1; a timeout SHALL clear last_row_valid.
REQ-025 In a single IDLE cycle, no requester SHALL be granted twice, and a grant SHALL be given only when the matching req_valid is high.

Reset
REQ-026 While rst=1 at posedge clk:
- state=IDLE;
- pointer=A;
- counter=0 and hit streak=0;
- last_row_valid=0 and last_row=0;
- mem_row=0, resp_data=0 and resp_err=0.
REQ-027 During reset, all strobes (req_ready_*, mem_valid, resp_valid_*) and busy SHALL be 0.
REQ-028 Reset mid-operation SHALL abandon the outstanding read with no response; a later mem_done is ignored per REQ-023.

Configuration
REQ-029 Macro ROW_HIT_PRIO_EN: when defined, row-hit priority is enabled as follows.
- If both requesters are valid and exactly one has req_row==last_row with last_row_valid=1, that requester SHALL be granted.
- The pointer SHALL be left unchanged by such a grant.
- A 3-bit hit streak SHALL count these consecutive overrides.
- When the streak reaches 4, plain round-robin SHALL apply for the next grant, and the streak SHALL reset to 0.
- Any grant that is not an override SHALL also reset the streak to 0.
REQ-030 When ROW_HIT_PRIO_EN is not defined, arbitration SHALL be pure round-robin per REQ-017, and the streak logic SHALL be absent.

Verification
REQ-031 Single read: A requests row 2, mem_done 3 cycles after mem_valid with content 0xDEADBEEF -> resp_valid_a=1, resp_data=0xDEADBEEF, resp_err=0.
REQ-032 Contention: A and B both held valid from reset with rows 9 and 15 -> grants in order A, B, A, B; mem_row sequence 9, 15, 9, 15.
REQ-033 Timeout: TIMEOUT=20, mem_done never asserted -> resp_valid for the granted requester exactly 20 cycles after WAIT entry, resp_err=1, resp_data=0.
REQ-034 Row hit with ROW_HIT_PRIO_EN, last_row=9, A row 9, B row 15, both valid continuously -> first grants A, A, A, A, then B.
REQ-035 Same stimulus as REQ-034 without ROW_HIT_PRIO_EN -> grants alternate starting at pointer position.
REQ-036 Reset asserted in WAIT, then mem_done pulsed -> no resp_valid, busy=0, and the next request is served normally.
